// File: rtl/pwm_gen_if.sv
// Register access bus between the I2C front end and the PWM generator.
//
// Handshake: the master holds wr_en high for exactly one clk_in cycle with
// wr_addr/wr_data valid in that cycle; the slave always accepts and answers
// with wr_ack high for the following cycle, one pulse per write. Reads have
// no strobe: rd_data returns the register selected by rd_addr one cycle
// after rd_addr is presented.
interface pwm_gen_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;
    logic [1:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  wr_ack, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output wr_ack, rd_data
    );
endinterface

// File: rtl/pwm_gen.sv
// Single-channel PWM generator stepped by rising edges of an asynchronous
// divided clock. Period and duty are double-buffered: writes land in shadow
// registers and move to the active set only at a period boundary, or on the
// next cycle while the channel is disabled.
module pwm_gen #(
    parameter int          WIDTH          = 8,
    parameter int          SYNC_STAGES    = 2,
    parameter int unsigned DEFAULT_PERIOD = 255,
    parameter int unsigned DEFAULT_DUTY   = 0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             tick_in,
    pwm_gen_if.slave         bus,
    output logic             pwm_out,
    output logic             cycle_start,
    output logic [WIDTH-1:0] cnt_out
);

    localparam logic [1:0] ADDR_PERIOD = 2'd0;
    localparam logic [1:0] ADDR_DUTY   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_prev;
    logic                   step;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] active_duty;
    logic             enable;
    logic             invert;
    logic             pending;

    logic wrap;
    logic load;
    logic wr_shadow;

    // A step is the first cycle in which the synchronised tick level is high.
    assign step = sync_q[SYNC_STAGES-1] & ~tick_prev;

    // Wrap happens on a step once the counter has reached the active period.
    assign wrap = enable & step & (cnt >= active_period);

    // Shadow values move to active at a wrap, or straight away when disabled.
    assign load = pending & (enable ? wrap : 1'b1);

    assign wr_shadow = bus.wr_en & ((bus.wr_addr == ADDR_PERIOD) | (bus.wr_addr == ADDR_DUTY));

    assign cnt_out = cnt;

    // Synchroniser chain on the asynchronous tick level plus edge history.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            tick_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_in};
            tick_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    // Every write, including the ignored STATUS write, is acked next cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_ack <= 1'b0;
        end else begin
            bus.wr_ack <= bus.wr_en;
        end
    end

    // Shadow/control registers and the boundary load into the active set.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            shadow_period <= WIDTH'(DEFAULT_PERIOD);
            shadow_duty   <= WIDTH'(DEFAULT_DUTY);
            active_period <= WIDTH'(DEFAULT_PERIOD);
            active_duty   <= WIDTH'(DEFAULT_DUTY);
            enable        <= 1'b0;
            invert        <= 1'b0;
            pending       <= 1'b0;
        end else begin
            // The load sees the pre-write shadow, so a colliding write is kept
            // pending for the following boundary.
            if (load) begin
                active_period <= shadow_period;
                active_duty   <= shadow_duty;
            end
            if (wr_shadow) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
            if (bus.wr_en) begin
                case (bus.wr_addr)
                    ADDR_PERIOD: shadow_period <= bus.wr_data;
                    ADDR_DUTY:   shadow_duty   <= bus.wr_data;
                    ADDR_CTRL: begin
                        enable <= bus.wr_data[0];
                        invert <= bus.wr_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Counter runs 0..active_period inclusive; held at 0 while disabled.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            cycle_start <= 1'b0;
        end else begin
            cycle_start <= wrap;
            if (!enable) begin
                cnt <= '0;
            end else if (step) begin
                if (cnt >= active_period) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Registered compare; a disabled channel rests at the inactive level.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable ? ((cnt < active_duty) ^ invert) : invert;
        end
    end

    // Registered readback; PERIOD and DUTY report the shadow values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= '0;
        end else begin
            case (bus.rd_addr)
                ADDR_PERIOD: bus.rd_data <= shadow_period;
                ADDR_DUTY:   bus.rd_data <= shadow_duty;
                ADDR_CTRL:   bus.rd_data <= {{(WIDTH-2){1'b0}}, invert, enable};
                ADDR_STATUS: bus.rd_data <= {{(WIDTH-1){1'b0}}, pending};
                default:     bus.rd_data <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed testbench for pwm_gen: register access, double-buffered updates,
// tick synchronisation, boundary cases and asynchronous reset.
module tb_pwm_gen;

    localparam int W = 8;

    logic         clk_in;
    logic         rst_n;
    logic         tick_in;
    logic         pwm_out;
    logic         cycle_start;
    logic [W-1:0] cnt_out;

    pwm_gen_if #(.WIDTH(W)) bus ();

    pwm_gen #(
        .WIDTH(W),
        .SYNC_STAGES(2),
        .DEFAULT_PERIOD(255),
        .DEFAULT_DUTY(0)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .tick_in(tick_in),
        .bus(bus),
        .pwm_out(pwm_out),
        .cycle_start(cycle_start),
        .cnt_out(cnt_out)
    );

    // clock
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state of the channel as the spec describes it.
    logic [W-1:0] m_cnt, m_per, m_duty, m_sh_per, m_sh_duty;
    bit           m_en, m_inv, m_pend, m_cs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = '0; m_per = 8'd255; m_duty = '0; m_sh_per = 8'd255; m_sh_duty = '0;
        m_en = 1'b0; m_inv = 1'b0; m_pend = 1'b0; m_cs = 1'b0;
    endfunction

    function automatic void model_step();
        m_cs = 1'b0;
        if (m_en) begin
            if (m_cnt >= m_per) begin
                m_cnt = '0;
                m_cs  = 1'b1;
                if (m_pend) begin
                    m_per  = m_sh_per;
                    m_duty = m_sh_duty;
                    m_pend = 1'b0;
                end
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end
    endfunction

    function automatic logic model_pwm();
        return m_en ? ((m_cnt < m_duty) ^ m_inv) : m_inv;
    endfunction

    // One register write starting on a falling edge; checks the ack pulse.
    task automatic wr(input logic [1:0] addr, input logic [W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk_in);
        bus.wr_en = 1'b0;
        chk("ack_hi", {31'd0, bus.wr_ack}, 32'd1);
        @(negedge clk_in);
        chk("ack_lo", {31'd0, bus.wr_ack}, 32'd0);
        case (addr)
            2'd0: begin m_sh_per = data; m_pend = 1'b1; end
            2'd1: begin m_sh_duty = data; m_pend = 1'b1; end
            2'd2: begin
                m_en = data[0]; m_inv = data[1];
                if (!m_en) m_cnt = '0;
            end
            default: ;
        endcase
        if (m_pend && !m_en) begin
            m_per = m_sh_per; m_duty = m_sh_duty; m_pend = 1'b0;
        end
    endtask

    task automatic rd(input string tag, input logic [1:0] addr, input logic [W-1:0] exp);
        bus.rd_addr = addr;
        @(negedge clk_in);
        chk(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    endtask

    // One slow tick: rise, check latency, counter, wrap pulse and output.
    task automatic do_tick(input string tag);
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk({tag, "_lat"}, {24'd0, cnt_out}, {24'd0, m_cnt});
        model_step();
        @(negedge clk_in);
        chk({tag, "_cnt"}, {24'd0, cnt_out}, {24'd0, m_cnt});
        chk({tag, "_cs"}, {31'd0, cycle_start}, {31'd0, m_cs});
        @(negedge clk_in);
        chk({tag, "_pwm"}, {31'd0, pwm_out}, {31'd0, model_pwm()});
        chk({tag, "_cs0"}, {31'd0, cycle_start}, 32'd0);
        tick_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk({tag, "_fall"}, {24'd0, cnt_out}, {24'd0, m_cnt});
    endtask

    initial begin
        int highs;
        bit seen;
        rst_n       = 1'b0;
        tick_in     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        model_reset();

        // reset state
        repeat (3) @(negedge clk_in);
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_out}, 32'd0);
        chk("rst_cs", {31'd0, cycle_start}, 32'd0);
        chk("rst_ack", {31'd0, bus.wr_ack}, 32'd0);
        chk("rst_rd", {24'd0, bus.rd_data}, 32'd0);
        rst_n = 1'b1;
        rd("def_per", 2'd0, 8'd255);
        rd("def_duty", 2'd1, 8'd0);
        rd("def_ctrl", 2'd2, 8'd0);
        rd("def_stat", 2'd3, 8'd0);

        // period 3, duty 2 loaded while disabled
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd2);
        rd("t1_stat", 2'd3, 8'd0);
        rd("t1_per", 2'd0, 8'd3);
        wr(2'd2, 8'd1);
        rd("t1_ctrl", 2'd2, 8'd1);
        chk("t1_pwm0", {31'd0, pwm_out}, 32'd1);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            do_tick("t1");
            highs += int'(pwm_out);
        end
        chk("t1_highs", highs, 4);
        chk("t1_cnt", {24'd0, cnt_out}, 32'd0);

        // period 9, duty 5; duty 8 written mid-period
        wr(2'd2, 8'd0);
        wr(2'd0, 8'd9);
        wr(2'd1, 8'd5);
        wr(2'd2, 8'd1);
        for (int i = 0; i < 4; i++) do_tick("t2a");
        chk("t2_cnt4", {24'd0, cnt_out}, 32'd4);
        wr(2'd1, 8'd8);
        rd("t2_pend1", 2'd3, 8'd1);
        for (int i = 0; i < 5; i++) do_tick("t2b");
        chk("t2_pwm9", {31'd0, pwm_out}, 32'd0);
        rd("t2_pend9", 2'd3, 8'd1);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick("t2c");
            highs += int'(pwm_out);
            if (i == 0) chk("t2_wrap", {24'd0, cnt_out}, 32'd0);
        end
        rd("t2_pend0", 2'd3, 8'd0);
        chk("t2_highs", highs, 8);

        // duty 0 then duty 20 (beyond period), then invert
        wr(2'd1, 8'd0);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            do_tick("t3a");
            seen = m_cs;
        end
        chk("t3_wrapa", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_d0", {31'd0, pwm_out}, 32'd0);
            do_tick("t3b");
        end
        wr(2'd1, 8'd20);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            do_tick("t3c");
            seen = m_cs;
        end
        chk("t3_wrapc", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_d20", {31'd0, pwm_out}, 32'd1);
            do_tick("t3d");
        end
        wr(2'd2, 8'd3);
        chk("t3_inv", {31'd0, pwm_out}, 32'd0);
        do_tick("t3e");
        chk("t3_inv2", {31'd0, pwm_out}, 32'd0);

        // fast edges one clock apart, then slow edges
        for (int i = 0; i < 3; i++) begin
            tick_in = 1'b1;
            @(negedge clk_in);
            tick_in = 1'b0;
            @(negedge clk_in);
            model_step();
        end
        repeat (6) @(negedge clk_in);
        chk("t4_fast", {24'd0, cnt_out}, {24'd0, m_cnt});
        tick_in = 1'b1;
        model_step();
        repeat (8) @(negedge clk_in);
        chk("t4_slow_r", {24'd0, cnt_out}, {24'd0, m_cnt});
        tick_in = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("t4_slow_f", {24'd0, cnt_out}, {24'd0, m_cnt});

        // asynchronous reset at cnt 5 with the output high
        wr(2'd2, 8'd0);
        wr(2'd0, 8'd9);
        wr(2'd1, 8'd8);
        wr(2'd2, 8'd1);
        for (int i = 0; i < 5; i++) do_tick("t5");
        chk("t5_cnt5", {24'd0, cnt_out}, 32'd5);
        chk("t5_pwm1", {31'd0, pwm_out}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rpwm", {31'd0, pwm_out}, 32'd0);
        chk("t5_rcnt", {24'd0, cnt_out}, 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        model_reset();
        rd("t5_ctrl", 2'd2, 8'd0);
        rd("t5_per", 2'd0, 8'd255);
        rd("t5_duty", 2'd1, 8'd0);

        // write in the exact wrap cycle while pending
        wr(2'd0, 8'd3);
        wr(2'd1, 8'd2);
        wr(2'd2, 8'd1);
        for (int i = 0; i < 3; i++) do_tick("t6a");
        wr(2'd1, 8'd1);
        tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 8'd3;
        model_step();
        m_sh_duty = 8'd3;
        m_pend    = 1'b1;
        @(negedge clk_in);
        bus.wr_en = 1'b0;
        chk("t6_cnt", {24'd0, cnt_out}, 32'd0);
        chk("t6_cs", {31'd0, cycle_start}, 32'd1);
        chk("t6_ack", {31'd0, bus.wr_ack}, 32'd1);
        @(negedge clk_in);
        chk("t6_ack0", {31'd0, bus.wr_ack}, 32'd0);
        chk("t6_pwm", {31'd0, pwm_out}, {31'd0, model_pwm()});
        tick_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rd("t6_stat", 2'd3, 8'd1);
        rd("t6_duty", 2'd1, 8'd3);
        do_tick("t6b");
        chk("t6_old", {31'd0, pwm_out}, 32'd0);
        for (int i = 0; i < 3; i++) do_tick("t6c");
        chk("t6_new", {31'd0, pwm_out}, 32'd1);
        rd("t6_stat0", 2'd3, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
